// File: rtl/fp_add_pkg.sv
// Shared types and helpers for the floating-point adder arbiter.
//   rm_t      : 2-bit rounding mode, same encoding as the adder's sign_select stage
//   flags_t   : {nan, inf, zero} result flags returned by the adder
//   onehot_dec: one bit of a one-hot decode of a requester id
package fp_add_pkg;

    typedef logic [1:0] rm_t;

    localparam rm_t RM_RNE = 2'b00;
    localparam rm_t RM_RZ  = 2'b01;
    localparam rm_t RM_RP  = 2'b10;
    localparam rm_t RM_RM  = 2'b11;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } flags_t;

    // Returns bit 'idx' of the one-hot decode of 'id'. Requester counts are at
    // most 8, so a 3-bit id covers every configuration.
    function automatic logic onehot_dec(input logic [2:0] id, input int idx);
        return id == 3'(idx);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
//   clk, reset : clock and synchronous active-high reset (pointer -> 0)
//   req        : per-requester request lines
//   advance    : the current grant was taken; move the pointer past it
//   grant      : one-hot (or zero) grant, combinational on req
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] ptr_next;
    logic          found;

    // Search from the pointer, wrapping modulo N; the first asserted request wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    // The requester just served drops to lowest priority.
    always_comb begin
        ptr_next = '0;
        if (grant_idx != PW'(N - 1)) begin
            ptr_next = grant_idx + PW'(1);
        end
    end

    // Pointer moves only on an accepted grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fixed-latency pipelined FP adder between NREQ requesters.
// Round-robin arbitration picks one request per cycle, the winner's operands
// are registered onto the adder issue port, and a tag pipe matching the adder
// latency carries the owner id so the result can be routed back.
//   req_valid/req_ready/req_a/req_b/req_sub/req_rm : requester ports (packed per id)
//   add_valid/add_a/add_b/add_sub/add_rm           : registered adder issue
//   add_res_valid/add_res/add_flags                : adder result
//   resp_valid/resp_res/resp_flags                 : one-hot routed response
//   proto_err                                      : sticky latency-mismatch error
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int LAT  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ*2-1:0] req_rm,
    output logic              add_valid,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_sub,
    output logic [1:0]        add_rm,
    input  logic              add_res_valid,
    input  logic [W-1:0]      add_res,
    input  logic [2:0]        add_flags,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_res,
    output logic [2:0]        resp_flags,
    output logic              proto_err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW  = $clog2(LAT + 1);

    logic [NREQ-1:0] grant;
    logic            handshake;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            sel_sub;
    rm_t             sel_rm;
    logic [IDW-1:0]  sel_id;
    logic [IDW-1:0]  issue_id;

    logic            tag_v  [LAT];
    logic [IDW-1:0]  tag_id [LAT];
    logic            tag_last_v;
    logic [IDW-1:0]  tag_last_id;

    logic [BW-1:0]   blank_cnt;
    logic            mismatch;
    logic            err_sticky;
    logic            resp_hit;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (handshake),
        .grant   (grant)
    );

    // No request is accepted while reset is held.
    assign req_ready = reset ? '0 : grant;
    assign handshake = |(req_valid & req_ready);

    // Select the granted requester's fields for the issue register.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        sel_rm  = RM_RNE;
        sel_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_sub = req_sub[i];
                sel_rm  = rm_t'(req_rm[i*2 +: 2]);
                sel_id  = IDW'(i);
            end
        end
    end

    // Issue register: strobe follows the handshake, data holds between issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            add_valid <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_sub   <= 1'b0;
            add_rm    <= RM_RNE;
            issue_id  <= '0;
        end else begin
            add_valid <= handshake;
            if (handshake) begin
                add_a    <= sel_a;
                add_b    <= sel_b;
                add_sub  <= sel_sub;
                add_rm   <= sel_rm;
                issue_id <= sel_id;
            end
        end
    end

    // Tag pipe mirrors the adder pipeline; it never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= add_valid;
            tag_id[0] <= issue_id;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign tag_last_v  = tag_v[LAT-1];
    assign tag_last_id = tag_id[LAT-1];

    // After reset the adder may still deliver results for discarded tags;
    // mismatches are ignored until those have drained (LAT cycles).
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_cnt <= BW'(LAT);
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - BW'(1);
        end
    end

    assign mismatch = (tag_last_v != add_res_valid) && (blank_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (mismatch) begin
            err_sticky <= 1'b1;
        end
    end

    // The error is visible in the cycle the mismatch occurs, then stays set.
    assign proto_err = !reset && (err_sticky || mismatch);

    assign resp_hit = !reset && tag_last_v && add_res_valid;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = resp_hit && onehot_dec(3'(tag_last_id), i);
        end
    end

    assign resp_res   = add_res;
    assign resp_flags = add_flags;

endmodule
